// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/STOP/INC state machine, tick prescaler, wrapping
// elapsed counter with auto-repeat increment. Optional lap capture under STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 10,
  parameter int CNT_W      = 16,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_START,
  input  logic             i_STOP,
  input  logic             i_INC,
  input  logic             i_CLEAR,
  input  logic             i_LAP,
  output logic [CNT_W-1:0] o_COUNT,
  output logic             o_ENABLE,
  output logic             o_RUNNING,
  output logic [1:0]       o_STATE,
  output logic             o_OVF,
  output logic [CNT_W-1:0] o_LAP,
  output logic             o_LAP_VALID
);

  localparam int PW      = $clog2(TICK_DIV);
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW      = $clog2(RPT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    INC  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic             rep_first_q, rep_first_d;
  logic             ovf_q, ovf_d;
  logic             enable_q;
  logic             step;
  logic             clear_all;
  logic [RW-1:0]    rep_thr;

  // First repeat step waits the long delay; later ones use the period.
  assign rep_thr = rep_first_q ? RW'(REPEAT_DLY) : RW'(REPEAT_PER);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_d     = presc_q;
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
    ovf_d       = ovf_q;
    step        = 1'b0;
    clear_all   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_START) begin
          state_d = RUN;
        end else if (i_INC) begin
          state_d     = INC;
          step        = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b1;
        end
      end
      RUN: begin
        // A tick coinciding with i_STOP still steps before leaving RUN.
        if (presc_q == PW'(TICK_DIV - 1)) begin
          presc_d = '0;
          step    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (i_STOP) state_d = STOP;
      end
      STOP: begin
        if (i_START) begin
          state_d = RUN;
        end else if (i_INC) begin
          state_d     = INC;
          step        = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b1;
        end else if (i_CLEAR) begin
          state_d   = IDLE;
          clear_all = 1'b1;
        end
      end
      INC: begin
        if (!i_INC) begin
          state_d = STOP;
        end else if ((rep_q + 1'b1) == rep_thr) begin
          step        = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (step) begin
      count_d = count_q + 1'b1;
      if (&count_q) ovf_d = 1'b1;
    end
    if (clear_all) begin
      count_d = '0;
      presc_d = '0;
      ovf_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q     <= IDLE;
      count_q     <= '0;
      presc_q     <= '0;
      rep_q       <= '0;
      rep_first_q <= 1'b0;
      ovf_q       <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
      ovf_q       <= ovf_d;
      enable_q    <= step;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [CNT_W-1:0] lap_q;
  logic             lap_valid_q;
  logic             lap_prev_q;

  // Edge history tracks i_LAP in every state; only RUN edges capture.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      lap_prev_q  <= 1'b0;
    end else begin
      lap_prev_q  <= i_LAP;
      lap_valid_q <= 1'b0;
      if (clear_all) begin
        lap_q <= '0;
      end else if (state_q == RUN && i_LAP && !lap_prev_q) begin
        lap_q       <= count_q;
        lap_valid_q <= 1'b1;
      end
    end
  end

  assign o_LAP       = lap_q;
  assign o_LAP_VALID = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap  = i_LAP;
  assign o_LAP       = '0;
  assign o_LAP_VALID = 1'b0;
`endif

  assign o_COUNT   = count_q;
  assign o_ENABLE  = enable_q;
  assign o_OVF     = ovf_q;
  assign o_STATE   = state_q;
  assign o_RUNNING = (state_q == RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a cycle model built from the behavioural
// rules is compared every cycle, plus literal checkpoints from the directed scenarios.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int CNT_W      = 4;
  localparam int REPEAT_DLY = 5;
  localparam int REPEAT_PER = 3;
`ifdef STOPWATCH_LAP_EN
  localparam int LAP_ON = 1;
`else
  localparam int LAP_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, inc = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [CNT_W-1:0] dut_count, dut_lap;
  logic             dut_en, dut_run, dut_ovf, dut_lapv;
  logic [1:0]       dut_state;

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
  ) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start), .i_STOP(stop), .i_INC(inc),
    .i_CLEAR(clear), .i_LAP(lap), .o_COUNT(dut_count), .o_ENABLE(dut_en),
    .o_RUNNING(dut_run), .o_STATE(dut_state), .o_OVF(dut_ovf), .o_LAP(dut_lap),
    .o_LAP_VALID(dut_lapv)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: states numbered as o_STATE; m_sub counts cycles into the current tick,
  // m_held counts cycles since entering INC, steps fall on DLY, DLY+PER, DLY+2*PER...
  int m_state, m_count, m_sub, m_held, m_lap;
  bit m_ovf, m_en, m_lapv, m_lprev;

  always @(posedge clk) begin : model
    int  nxt;
    bit  stp;
    if (!rst_n) begin
      m_state = 0; m_count = 0; m_sub = 0; m_held = 0; m_lap = 0;
      m_ovf = 0; m_en = 0; m_lapv = 0; m_lprev = 0;
    end else begin
      nxt = m_state;
      stp = 0;
      m_lapv = 0;
      if (LAP_ON == 1 && m_state == 1 && lap && !m_lprev) begin
        m_lap  = m_count;
        m_lapv = 1;
      end
      m_lprev = lap;
      case (m_state)
        0: if (start) nxt = 1;
           else if (inc) begin nxt = 3; stp = 1; m_held = 0; end
        1: begin
          m_sub++;
          if (m_sub == TICK_DIV) begin m_sub = 0; stp = 1; end
          if (stop) nxt = 2;
        end
        2: if (start) nxt = 1;
           else if (inc) begin nxt = 3; stp = 1; m_held = 0; end
           else if (clear) begin
             nxt = 0; m_count = 0; m_sub = 0; m_ovf = 0; m_lap = 0;
           end
        default: if (!inc) nxt = 2;
           else begin
             m_held++;
             if (m_held == REPEAT_DLY ||
                 (m_held > REPEAT_DLY && (m_held - REPEAT_DLY) % REPEAT_PER == 0))
               stp = 1;
           end
      endcase
      if (stp) begin
        m_count = (m_count + 1) % (1 << CNT_W);
        if (m_count == 0) m_ovf = 1;
      end
      m_en    = stp;
      m_state = nxt;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("count", dut_count, m_count);
      check("enable", dut_en, m_en);
      check("state", dut_state, m_state);
      check("running", dut_run, (m_state == 1) ? 1 : 0);
      check("ovf", dut_ovf, m_ovf);
      check("lap", dut_lap, m_lap);
      check("lap_valid", dut_lapv, m_lapv);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  pulses;
    bit  found;

    cyc(2);
    cmp_en = 1;
    check("rst_count", dut_count, 0);
    check("rst_state", dut_state, 0);
    check("rst_ovf", dut_ovf, 0);
    check("rst_enable", dut_en, 0);
    rst_n = 1'b1;

    // Start, steps at 4/8/12 cycles after RUN entry
    start = 1; cyc(1); start = 0;
    cyc(3); check("t1_pre_tick", dut_count, 0);
    cyc(1); check("t1_step1", dut_count, 1); check("t1_en1", dut_en, 1);
    cyc(4); check("t1_step2", dut_count, 2);
    cyc(4); check("t1_step3", dut_count, 3); check("t1_en3", dut_en, 1);

    // Stop with prescaler at 2, resume: step 2 cycles later
    cyc(5); stop = 1; cyc(1); stop = 0;
    check("t2_stopped", dut_state, 2); check("t2_count", dut_count, 4);
    cyc(10);
    start = 1; cyc(1); start = 0;
    cyc(1); check("t2_resume1", dut_count, 4); check("t2_en_lo", dut_en, 0);
    cyc(1); check("t2_resume2", dut_count, 5); check("t2_en_hi", dut_en, 1);
    stop = 1; cyc(1); stop = 0;
    clear = 1; cyc(1); clear = 0;
    check("t2_clr_count", dut_count, 0); check("t2_clr_state", dut_state, 0);

    // Held INC from IDLE for 20 cycles
    inc = 1; cyc(20);
    check("t3_inc_state", dut_state, 3); check("t3_inc_count", dut_count, 6);
    inc = 0; cyc(1);
    check("t3_rel_state", dut_state, 2); check("t3_rel_count", dut_count, 6);

    // Preload to 15 then wrap in RUN
    for (int i = 0; i < 9; i++) begin
      inc = 1; cyc(1); inc = 0; cyc(1);
    end
    check("t4_preload", dut_count, 15); check("t4_ovf_lo", dut_ovf, 0);
    start = 1; cyc(1); start = 0;
    cyc(3); check("t4_pre_wrap", dut_count, 15);
    cyc(1); check("t4_wrap", dut_count, 0); check("t4_ovf_hi", dut_ovf, 1);
    stop = 1; cyc(1); stop = 0;
    check("t4_ovf_sticky", dut_ovf, 1);
    clear = 1; cyc(1); clear = 0;
    check("t4_clr_count", dut_count, 0); check("t4_clr_ovf", dut_ovf, 0);
    check("t4_clr_state", dut_state, 0);

    // Lap at count 7 held 10 cycles, then lap in STOP
    start = 1; cyc(1); start = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (dut_count == 7) found = 1;
    end
    check("t5_reach7", found, 1);
    lap = 1; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (dut_lapv) pulses++;
    end
    lap = 0;
    check("t5_lap_pulses", pulses, LAP_ON);
    check("t5_lap_value", dut_lap, (LAP_ON == 1) ? 7 : 0);
    stop = 1; cyc(1); stop = 0;
    cyc(1); lap = 1; pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (dut_lapv) pulses++;
    end
    lap = 0; cyc(1);
    check("t5_stop_pulses", pulses, 0);
    check("t5_stop_lap", dut_lap, (LAP_ON == 1) ? 7 : 0);

    // Reset mid-RUN and mid-INC
    start = 1; cyc(1); start = 0; cyc(3);
    check("t6_running", dut_run, 1);
    rst_n = 0; cyc(1);
    check("t6_run_rst_state", dut_state, 0); check("t6_run_rst_count", dut_count, 0);
    check("t6_run_rst_lap", dut_lap, 0); check("t6_run_rst_run", dut_run, 0);
    rst_n = 1;
    inc = 1; cyc(3);
    check("t6_in_inc", dut_state, 3);
    rst_n = 0; cyc(1);
    check("t6_inc_rst_state", dut_state, 0); check("t6_inc_rst_count", dut_count, 0);
    check("t6_inc_rst_en", dut_en, 0);
    inc = 0; rst_n = 1; cyc(2);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Parametrised stopwatch controller: a start/stop/increment state machine, a programmable tick prescaler, a CNT_W-bit elapsed-time counter with wrap flag, auto-repeat on a held increment button, and an optional lap-capture register. It sits between the debounced front-panel buttons and the display/BCD conversion logic, normally clocked at 1 kHz. It drives both the count value and a one-cycle enable pulse per count step.

## Interface
- TICK_DIV, 10: clock cycles per count tick in RUN (≥2).
- CNT_W, 16: width of count and lap registers.
- REPEAT_DLY, 500: cycles i_INC must stay held in INC before the first auto-repeat step (≥1).
- REPEAT_PER, 100: cycles between subsequent auto-repeat steps (≥1).

- i_CLK  in  1  clock; all logic on rising edge.
- i_RST_N  in  1  reset; synchronous, active-low.
- i_START  in  1  start/resume request (level).
- i_STOP  in  1  stop request (level).
- i_INC  in  1  manual increment button (level).
- i_CLEAR  in  1  clear count; honoured only in STOP.
- i_LAP  in  1  lap capture button; rising edge acts.
- o_COUNT  out  CNT_W  elapsed count.
- o_ENABLE  out  1  one-cycle pulse per count step.
- o_RUNNING  out  1  high while state is RUN.
- o_STATE  out  2  IDLE=00, RUN=01, STOP=10, INC=11.
- o_OVF  out  1  sticky count wrap flag.
- o_LAP  out  CNT_W  last captured lap value.
- o_LAP_VALID  out  1  one-cycle pulse when o_LAP is updated.

## Operation
- Reset (i_RST_N low at an edge): state IDLE; o_COUNT, prescaler, repeat counter, o_OVF, o_LAP, o_LAP_VALID, o_ENABLE all 0; LAP edge detector history 0. Reset overrides all inputs.
- IDLE: i_START → RUN; else i_INC → INC; else stay.
- RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0 and o_COUNT increments. i_STOP → STOP. i_START, i_INC, i_CLEAR ignored.
- STOP: prescaler held, not cleared, so a resume keeps the partial tick. i_START → RUN; else i_INC → INC; else i_CLEAR → IDLE with o_COUNT, prescaler, o_OVF, o_LAP zeroed.
- INC: the transition edge into INC adds 1 to o_COUNT and zeroes the repeat counter. While i_INC stays high, further +1 steps occur REPEAT_DLY cycles after entry, then every REPEAT_PER cycles. i_INC low → STOP, with no step on that edge.
- Step (any +1): o_COUNT wraps from 2^CNT_W-1 to 0 and sets o_OVF; o_OVF stays set until clear or reset.
- Lap: on an i_LAP rising edge while in RUN, o_LAP ← o_COUNT value before that edge and o_LAP_VALID pulses. A held i_LAP captures once. Lap edges are ignored outside RUN, but the edge history still updates.
- Priority in RUN when a tick coincides with i_STOP: the tick step is applied, then STOP is entered.

## Timing
- All outputs are registered except o_RUNNING and o_STATE, which are decoded from the state register. No combinational input-to-output paths.
- o_ENABLE is high in exactly the cycle in which o_COUNT shows its new value.
- START → RUN: first step TICK_DIV cycles after the RUN entry edge when starting from prescaler 0.
- Lap: o_LAP and o_LAP_VALID update at the edge that samples i_LAP high with previous sample low.

## Configuration
- STOPWATCH_LAP_EN defined: lap register, edge detector and o_LAP_VALID are implemented as above.
- Not defined: no lap logic is built. o_LAP is tied to 0, o_LAP_VALID to 0, and i_LAP is ignored. All other behaviour is identical.

## Test plan
- Reset, then START for 1 cycle (TICK_DIV=4): steps at 4, 8, 12 cycles after RUN entry. o_COUNT=1,2,3, each coincident with a single o_ENABLE pulse.
- RUN 6 cycles (TICK_DIV=4), STOP, wait 10, START: next step 2 cycles after resume, because the prescaler was held at 2.
- From IDLE hold i_INC 20 cycles (REPEAT_DLY=5, REPEAT_PER=3): steps at entry, +5, +8, +11, +14, +17 → o_COUNT=6; release → o_STATE=10.
- CNT_W=4, preload to 15 via INC, then START: next tick gives o_COUNT=0 and o_OVF=1. STOP+CLEAR → o_COUNT=0, o_OVF=0, o_STATE=00.
- LAP edge at o_COUNT=7 in RUN, held 10 cycles → o_LAP=7, one o_LAP_VALID pulse. LAP in STOP → no capture. Without STOPWATCH_LAP_EN, o_LAP stays 0.
- Drive i_RST_N low mid-RUN and mid-INC: at the next edge all outputs return to reset values and o_STATE=00.
